// File: rtl/vector_reg_file_if.sv
// Writeback/decode bundle for vector_reg_file: one write port, two read ports, write counter.
interface vector_reg_file_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 128
);
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_vector_op;
    logic [3:0]        wb_lane_mask;
    logic [DATA_W-1:0] wb_result;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_vector_op;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [15:0]       wr_count;

    modport master (
        output wb_reg_write, wb_rd, wb_vector_op, wb_lane_mask, wb_result,
        output id_rs1, id_rs2, id_vector_op,
        input  id_rd1, id_rd2, wr_count
    );

    modport slave (
        input  wb_reg_write, wb_rd, wb_vector_op, wb_lane_mask, wb_result,
        input  id_rs1, id_rs2, id_vector_op,
        output id_rd1, id_rd2, wr_count
    );
endinterface

// File: rtl/vector_reg_file.sv
// 4-lane vector register file: scalar/masked-vector writeback, two combinational decode reads.
// Optional same-cycle WB->decode bypass enabled by defining REGFILE_WB_BYPASS_EN.
module vector_reg_file #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 128,
    parameter int LANE_W   = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    vector_reg_file_if.slave rf
);
    localparam int LANES = 4;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    logic [DATA_W-1:0] wb_merge;
    logic              wb_commit;
    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;

    // Post-merge write value; shared by the commit path and the bypass path.
    always_comb begin
        wb_merge = regs_q[rf.wb_rd];
        if (!rf.wb_vector_op) begin
            wb_merge = {LANES{rf.wb_result[LANE_W-1:0]}};
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (rf.wb_lane_mask[i]) begin
                    wb_merge[i*LANE_W +: LANE_W] = rf.wb_result[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign wb_commit = rf.wb_reg_write && (rf.wb_rd != '0) &&
                       (!rf.wb_vector_op || (rf.wb_lane_mask != 4'b0000));

    always_comb begin
        wr_count_d = wr_count_q;
        if (wb_commit && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (wb_commit) begin
                regs_q[rf.wb_rd] <= wb_merge;
            end
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        raw1 = (rf.id_rs1 == '0) ? '0 : regs_q[rf.id_rs1];
        raw2 = (rf.id_rs2 == '0) ? '0 : regs_q[rf.id_rs2];
`ifdef REGFILE_WB_BYPASS_EN
        if (rf.wb_reg_write && (rf.wb_rd != '0) && (rf.wb_rd == rf.id_rs1)) begin
            raw1 = wb_merge;
        end
        if (rf.wb_reg_write && (rf.wb_rd != '0) && (rf.wb_rd == rf.id_rs2)) begin
            raw2 = wb_merge;
        end
`endif
    end

    // Gating with rst_n keeps the bypass path from leaking data while reset is held.
    always_comb begin
        rf.id_rd1 = '0;
        rf.id_rd2 = '0;
        if (rst_n) begin
            rf.id_rd1 = rf.id_vector_op ? raw1 : {LANES{raw1[LANE_W-1:0]}};
            rf.id_rd2 = rf.id_vector_op ? raw2 : {LANES{raw2[LANE_W-1:0]}};
        end
    end

    assign rf.wr_count = wr_count_q;

endmodule

// File: tb/tb_vector_reg_file.sv
// Randomized scoreboard bench for vector_reg_file with a lane-level reference model.
module tb_vector_reg_file;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vector_reg_file_if #(.ADDR_W(4), .DATA_W(128)) bus ();

    vector_reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    typedef struct {
        logic [127:0] rd1;
        logic [127:0] rd2;
        logic [15:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [16][4];
    int          count;

    function automatic logic [127:0] stored(input int r);
        logic [127:0] v;
        for (int l = 0; l < 4; l++) v[l*32 +: 32] = mem[r][l];
        return (r == 0) ? 128'd0 : v;
    endfunction

    function automatic logic [31:0] new_lane(input int r, input int l, input logic vop,
                                             input logic [3:0] mask, input logic [127:0] res);
        if (!vop) return res[31:0];
        if (mask[l]) return res[l*32 +: 32];
        return mem[r][l];
    endfunction

    function automatic logic [127:0] readval(input int rs, input logic we, input int rd,
                                             input logic vop, input logic [3:0] mask,
                                             input logic [127:0] res);
        logic [127:0] v;
        if (rs == 0) return 128'd0;
        v = stored(rs);
`ifdef REGFILE_WB_BYPASS_EN
        if (we && rd == rs) begin
            for (int l = 0; l < 4; l++) v[l*32 +: 32] = new_lane(rd, l, vop, mask, res);
        end
`endif
        return v;
    endfunction

    function automatic logic [127:0] fmt(input logic [127:0] v, input logic idv);
        return idv ? v : {4{v[31:0]}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input logic rst_lvl, input logic we, input logic [3:0] rd,
                        input logic vop, input logic [3:0] mask, input logic [127:0] res,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic idv);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst_lvl;
        bus.wb_reg_write = we;
        bus.wb_rd        = rd;
        bus.wb_vector_op = vop;
        bus.wb_lane_mask = mask;
        bus.wb_result    = res;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_vector_op = idv;
        if (!rst_lvl) begin
            for (int r = 0; r < 16; r++) for (int l = 0; l < 4; l++) mem[r][l] = 32'd0;
            count = 0;
            e.rd1 = '0;
            e.rd2 = '0;
            e.cnt = '0;
        end else begin
            e.rd1 = fmt(readval(int'(rs1), we, int'(rd), vop, mask, res), idv);
            e.rd2 = fmt(readval(int'(rs2), we, int'(rd), vop, mask, res), idv);
            e.cnt = 16'(count);
        end
        q.push_back(e);
        if (rst_lvl && we && rd != 0 && (!vop || mask != 4'b0000)) begin
            for (int l = 0; l < 4; l++) mem[rd][l] = new_lane(int'(rd), l, vop, mask, res);
            if (count < 65535) count++;
        end
    endtask

    task automatic read_only(input logic [3:0] rs1, input logic [3:0] rs2, input logic idv);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 128'd0, rs1, rs2, idv);
    endtask

    // Monitor: every cycle the read ports present data; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("id_rd1", bus.id_rd1, e.rd1);
                check("id_rd2", bus.id_rd2, e.rd2);
                check("wr_count", {112'd0, bus.wr_count}, {112'd0, e.cnt});
            end
        end
    end

    initial begin
        logic [127:0] r128;
        rst_n = 1'b0;
        count = 0;
        for (int r = 0; r < 16; r++) for (int l = 0; l < 4; l++) mem[r][l] = 32'd0;
        bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_vector_op = 1'b0;
        bus.wb_lane_mask = '0;   bus.wb_result = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_vector_op = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd5, 1'b0, 4'hF, 128'hFFFF, 4'd5, 4'd5, 1'b1);

        // Scalar write replicates lane0.
        step(1'b1, 1'b1, 4'd3, 1'b0, 4'b0010, 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF, 4'd0, 4'd0, 1'b1);
        read_only(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        check("scalar_rd1", bus.id_rd1, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

        // Masked vector write: lanes 0 and 2 take new data.
        step(1'b1, 1'b1, 4'd5, 1'b1, 4'b1111, 128'h11111111_22222222_33333333_44444444, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd5, 1'b1, 4'b0101, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 4'd0, 4'd0, 1'b1);
        read_only(4'd5, 4'd3, 1'b1);
        @(negedge clk);
        check("masked_rd1", bus.id_rd1, 128'h11111111_BBBBBBBB_33333333_DDDDDDDD);

        // Register 0 discards writes and the counter holds.
        step(1'b1, 1'b1, 4'd0, 1'b1, 4'hF, {128{1'b1}}, 4'd0, 4'd0, 1'b1);
        read_only(4'd0, 4'd0, 1'b1);
        @(negedge clk);
        check("reg0_rd1", bus.id_rd1, 128'd0);
        check("reg0_count", {112'd0, bus.wr_count}, 128'd3);

        // Empty-mask vector write is not a write.
        step(1'b1, 1'b1, 4'd5, 1'b1, 4'b0000, {128{1'b1}}, 4'd0, 4'd0, 1'b1);
        read_only(4'd5, 4'd0, 1'b1);
        @(negedge clk);
        check("mask0_rd1", bus.id_rd1, 128'h11111111_BBBBBBBB_33333333_DDDDDDDD);
        check("mask0_count", {112'd0, bus.wr_count}, 128'd3);

        // Same-cycle write/read of rd=7.
        step(1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 128'h12345678, 4'd0, 4'd7, 1'b1);
        @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
        check("bypass_rd2", bus.id_rd2, {4{32'h12345678}});
`else
        check("nobypass_rd2", bus.id_rd2, 128'd0);
`endif
        read_only(4'd7, 4'd7, 1'b0);
        @(negedge clk);
        check("after_write_rd2", bus.id_rd2, {4{32'h12345678}});

        for (int i = 0; i < 400; i++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
                 ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom), r128,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom));
        end

        // Mid-run reset, with writes attempted while held.
        for (int rs = 0; rs < 16; rs++) begin
            step(1'b0, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 4'hF, {4{$urandom}}, 4'(rs), 4'(15 - rs), 1'($urandom));
        end
        for (int rs = 0; rs < 16; rs++) read_only(4'(rs), 4'(rs), 1'b1);

        // Saturation: 65535 writes reach FFFF, further writes do not wrap.
        for (int i = 0; i < 65538; i++) begin
            step(1'b1, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 4'd0, {96'd0, $urandom},
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end
        read_only(4'd1, 4'd2, 1'b0);
        @(negedge clk);
        check("sat_count", {112'd0, bus.wr_count}, 128'h0000_FFFF);

        @(posedge clk);
        @(negedge clk);
        check("queue_drained", 128'(q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
